// File: rtl/sqrt_iter_pkg.sv
// Shared definitions for the iterative square-root unit: FSM encoding,
// default geometry and the configuration legality check.
package sqrt_iter_pkg;

  localparam int DEF_IN_W = 24;
  localparam int DEF_BPC  = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic bit bpc_legal(input int in_w, input int bpc);
    return ((bpc == 1) || (bpc == 2)) && ((in_w % bpc) == 0);
  endfunction

endpackage

// File: rtl/sqrt_step.sv
// One restoring square-root digit step: bring down two radicand bits,
// trial-subtract {Q,01}, keep the difference only if it is non-negative.
module sqrt_step
  import sqrt_iter_pkg::*;
#(
  parameter int W = DEF_IN_W
) (
  input  logic [W+1:0] rem_i,
  input  logic [W-1:0] root_i,
  input  logic [1:0]   bits_i,
  output logic [W+1:0] rem_o,
  output logic [W-1:0] root_o
);

  logic [W+3:0] shifted;
  logic [W+3:0] trial;
  logic [W+3:0] diff;
  logic         ge;
  logic         unused_diff;

  assign shifted = {rem_i, bits_i};
  assign trial   = {2'b00, root_i, 2'b01};
  assign diff    = shifted - trial;
  assign ge      = (shifted >= trial);

  // The remainder is bounded by 2*root, so the top diff bits are always zero when kept.
  assign rem_o       = ge ? diff[W+1:0] : shifted[W+1:0];
  assign root_o      = {root_i[W-2:0], ge};
  assign unused_diff = ^diff[W+3:W+2];

endmodule

// File: rtl/sqrt_iter.sv
// Iterative fixed-point mantissa square root: root = floor(sqrt(X * 2^IN_W)),
// retiring BPC root bits per clock, with valid/ready handshakes on both sides.
module sqrt_iter
  import sqrt_iter_pkg::*;
#(
  parameter int IN_W = DEF_IN_W,
  parameter int BPC  = DEF_BPC
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [IN_W-1:0] out_root,
  output logic [IN_W:0]   out_rem,
  output logic            out_sticky
);

  localparam int STEPS = IN_W / BPC;
  localparam int CNT_W = $clog2(STEPS + 1);

  if (!bpc_legal(IN_W, BPC)) begin : g_bad_cfg
    $error("sqrt_iter: BPC must be 1 or 2 and divide IN_W");
  end

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*IN_W-1:0]   rad_q, rad_d;
  logic [IN_W+1:0]     rem_q, rem_d;
  logic [IN_W-1:0]     root_q, root_d;
  logic                unused_rem_msb;

  logic [IN_W+1:0]     rem_c  [BPC+1];
  logic [IN_W-1:0]     root_c [BPC+1];

  assign rem_c[0]  = rem_q;
  assign root_c[0] = root_q;

  // Step gi consumes the radicand pair gi positions below the current top.
  for (genvar gi = 0; gi < BPC; gi++) begin : g_step
    sqrt_step #(.W(IN_W)) u_step (
      .rem_i  (rem_c[gi]),
      .root_i (root_c[gi]),
      .bits_i (rad_q[2*IN_W-1-2*gi -: 2]),
      .rem_o  (rem_c[gi+1]),
      .root_o (root_c[gi+1])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (in_valid)                 state_d = ST_RUN;
        ST_RUN:  if (cnt_q == CNT_W'(1))       state_d = ST_DONE;
        ST_DONE: if (out_ready)                state_d = ST_IDLE;
        default:                               state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    rad_d  = rad_q;
    rem_d  = rem_q;
    root_d = root_q;
    if (!flush) begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            cnt_d  = CNT_W'(STEPS);
            rad_d  = {in_data, {IN_W{1'b0}}};
            rem_d  = '0;
            root_d = '0;
          end
        end
        ST_RUN: begin
          cnt_d  = cnt_q - CNT_W'(1);
          rad_d  = rad_q << (2 * BPC);
          rem_d  = rem_c[BPC];
          root_d = root_c[BPC];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      rad_q  <= '0;
      rem_q  <= '0;
      root_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      rad_q  <= rad_d;
      rem_q  <= rem_d;
      root_q <= root_d;
    end
  end

  always_comb begin
    in_ready   = (state_q == ST_IDLE);
    out_valid  = (state_q == ST_DONE);
    out_root   = out_valid ? root_q : '0;
    out_rem    = out_valid ? rem_q[IN_W:0] : '0;
    out_sticky = out_valid & (|rem_q[IN_W:0]);
  end

  // Final remainder never exceeds 2*root, so its MSB is structurally zero.
  assign unused_rem_msb = rem_q[IN_W+1];

endmodule

// File: doc/sqrt_iter.md
SQRT_ITER -- requirements
Module: sqrt_iter

Interface
REQ-001 SHALL have parameter IN_W, default 24, giving the operand width; the root is IN_W bits.
REQ-002 SHALL have parameter BPC, default 1, giving root bits retired per cycle; legal values are 1 and 2, and IN_W mod BPC = 0.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port flush, input, 1 bit: synchronous abort of any operation in progress.
REQ-006 SHALL have port in_valid, input, 1 bit: operand offered.
REQ-007 SHALL have port in_ready, output, 1 bit: unit can accept an operand.
REQ-008 SHALL have port in_data, input, IN_W bits: operand X.
REQ-009 SHALL have port out_valid, output, 1 bit: result available.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-011 SHALL have port out_root, output, IN_W bits: floor(sqrt(X * 2^IN_W)).
REQ-012 SHALL have port out_rem, output, IN_W+1 bits: X*2^IN_W - out_root^2.
REQ-013 SHALL have port out_sticky, output, 1 bit: OR-reduction of out_rem, for rounding.

Function
REQ-014 SHALL treat the radicand as the 2*IN_W-bit value {in_data, IN_W zeros}, making the root a fixed-point mantissa root.
REQ-015 SHALL implement a non-restoring/restoring digit recurrence; each step shifts in 2 radicand bits, trial-subtracts {Q,01}, and sets the root bit to 1 only when the difference is non-negative.
REQ-016 SHALL use a 3-state FSM: IDLE, RUN, DONE.
REQ-017 SHALL drive in_ready = 1 only in IDLE.
REQ-018 SHALL, in IDLE, capture the radicand when in_valid=1 at a clock edge, clear the root and partial remainder, load the step counter with IN_W/BPC, and go to RUN.
REQ-019 SHALL, in RUN, perform BPC recurrence steps per cycle and decrement the counter; on the cycle the counter reaches 0 it SHALL go to DONE.
REQ-020 SHALL produce out_valid exactly IN_W/BPC cycles after the acceptance edge (24 for the defaults, 12 with BPC=2).
REQ-021 SHALL hold out_valid=1 and keep out_root, out_rem and out_sticky stable in DONE until out_ready=1 at an edge, then return to IDLE.
REQ-022 SHALL NOT accept a new operand in the same cycle a result is consumed; throughput is one operation per IN_W/BPC+2 cycles.
REQ-023 SHALL size the partial remainder at IN_W+2 bits, so out_rem never overflows; the maximum out_rem is 2*out_root.
REQ-024 SHALL, when flush=1, go to IDLE at the next edge from any state, dropping the operation and any pending result; flush has priority over in_valid and out_ready.
REQ-025 SHALL hold out_root, out_rem and out_sticky at 0 whenever out_valid=0.

Reset
REQ-026 SHALL, while rst_n=0, force the FSM to IDLE, the counter, root, remainder and radicand registers to 0, and outputs to in_ready=1, out_valid=0, out_root=0, out_rem=0, out_sticky=0.
REQ-027 SHALL abandon an operation in progress when reset asserts mid-operation; after release the unit accepts a fresh operand as from power-up.

Structure
REQ-028 SHALL place the FSM state encoding and the default IN_W/BPC values in the shared FPU package.
REQ-029 SHALL implement the single recurrence step in one combinational sub-module, sqrt_step, instantiated BPC times in a chain.
REQ-030 SHALL reject an illegal BPC value or IN_W mod BPC != 0 at elaboration.

Verification
REQ-031 SHALL cover IN_W=24, BPC=1 with in_data=24'h400000 -> out_valid 24 cycles after acceptance, out_root=24'h800000, out_rem=0, out_sticky=0.
REQ-032 SHALL cover in_data=24'hFFFFFF -> out_root=24'hFFFFFF, out_rem=25'h0FFFFFF, out_sticky=1.
REQ-033 SHALL cover in_data=24'h000002 -> out_root=24'h0016A0, out_rem=25'h0001C00, out_sticky=1, and in_data=0 -> root 0, rem 0.
REQ-034 SHALL cover back-pressure: out_ready held 0 for 10 cycles after out_valid -> outputs stable and in_ready=0 throughout; out_ready=1 -> IDLE next cycle.
REQ-035 SHALL cover flush at RUN cycle 5, and rst_n pulsed at RUN cycle 12 -> IDLE, out_valid never asserted, next operand (24'h000001) returns root 24'h001000.
REQ-036 SHALL cover BPC=2 with 1000 random operands -> results match the BPC=1 results, with latency 12.
